// File: rtl/npc_predict_unit.sv
// rtl/npc_predict_unit.sv - next-PC register with ID-stage target resolution and optional BTB (NPC_BTB_EN)
// NPC_BTB_EN defined: direct-mapped BTB with 2-bit counters; undefined: static not-taken prediction.
module npc_predict_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_if,
  output logic [ADDR_W-1:0] pred_npc_if,
  input  logic              id_valid,
  input  logic [1:0]        id_kind,
  input  logic              id_taken,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [ADDR_W-1:0] id_pcadd4,
  input  logic [31:0]       id_immext,
  input  logic [ADDR_W-1:0] id_gpr_rs,
  input  logic [ADDR_W-1:0] id_pred_npc,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [1:0] KIND_BR = 2'b01;
  localparam logic [1:0] KIND_J  = 2'b10;
  localparam logic [1:0] KIND_JR = 2'b11;
  // Bits of id_pcadd4 that a j/jal keeps (the 256 MB region); empty when ADDR_W = 28.
  localparam logic [ADDR_W-1:0] REGION_MASK = ADDR_W'(32'hF000_0000);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] actual_pc;
  logic [31:0]       imm_shift;

  assign seq_pc     = pc_if + ADDR_W'(4);
  assign imm_shift  = id_immext << 2;
  assign br_target  = id_pcadd4 + imm_shift[ADDR_W-1:0];
  assign jmp_target = (id_pcadd4 & REGION_MASK) | ADDR_W'({id_immext[25:0], 2'b00});

  always_comb begin
    actual_pc = id_pcadd4;
    case (id_kind)
      KIND_BR: actual_pc = id_taken ? br_target : id_pcadd4;
      KIND_J:  actual_pc = jmp_target;
      KIND_JR: actual_pc = id_gpr_rs;
      default: actual_pc = id_pcadd4;
    endcase
  end

  assign flush       = id_valid && (actual_pc != id_pred_npc);
  assign redirect_pc = actual_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if <= RESET_PC;
    end else if (flush) begin
      pc_if <= redirect_pc;
    end else if (!stall) begin
      pc_if <= pred_npc_if;
    end
  end

`ifdef NPC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [ADDR_W-1:0]    btb_target [BTB_DEPTH];
  logic [1:0]           btb_ctr    [BTB_DEPTH];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              pred_hit, wr_en, wr_hit;
  logic [1:0]        wr_ctr;
  logic [ADDR_W-1:0] wr_target;
  logic              unused_pc_lsb;

  assign rd_idx   = pc_if[IDX_W+1:2];
  assign rd_tag   = pc_if[ADDR_W-1:IDX_W+2];
  assign wr_idx   = id_pc[IDX_W+1:2];
  assign wr_tag   = id_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsb = ^id_pc[1:0];

  // Lookup reads the arrays before this cycle's update lands at the edge.
  assign pred_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag) && btb_ctr[rd_idx][1];
  assign pred_npc_if = pred_hit ? btb_target[rd_idx] : seq_pc;

  // Indirect jumps are never cached: their targets change per call site.
  assign wr_en     = id_valid && ((id_kind == KIND_BR) || (id_kind == KIND_J));
  assign wr_hit    = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign wr_target = (id_kind == KIND_J) ? jmp_target : br_target;

  always_comb begin
    wr_ctr = 2'b11;
    if (id_kind == KIND_BR) begin
      if (!wr_hit) begin
        wr_ctr = id_taken ? 2'b10 : 2'b01;
      end else if (id_taken) begin
        wr_ctr = (btb_ctr[wr_idx] == 2'b11) ? 2'b11 : btb_ctr[wr_idx] + 2'b01;
      end else begin
        wr_ctr = (btb_ctr[wr_idx] == 2'b00) ? 2'b00 : btb_ctr[wr_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (wr_en) begin
      btb_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= wr_target;
      btb_ctr[wr_idx]    <= wr_ctr;
    end
  end
`else
  localparam int unused_btb_depth = BTB_DEPTH;
  logic unused_id_pc;

  assign unused_id_pc = ^id_pc;
  assign pred_npc_if  = seq_pc;
`endif

endmodule

// File: tb/tb_npc_predict_unit.sv
// tb/tb_npc_predict_unit.sv - scoreboard bench for npc_predict_unit against a behavioural next-PC/BTB model
module tb_npc_predict_unit;

  localparam int          DEPTH = 16;
  localparam int          IW    = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;
`ifdef NPC_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, id_valid, id_taken, flush;
  logic [1:0]  id_kind;
  logic [31:0] pc_if, pred_npc_if, id_pc, id_pcadd4, id_immext, id_gpr_rs, id_pred_npc, redirect_pc;

  always #5 clk = ~clk;

  npc_predict_unit #(.ADDR_W(32), .BTB_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_if(pc_if), .pred_npc_if(pred_npc_if),
    .id_valid(id_valid), .id_kind(id_kind), .id_taken(id_taken), .id_pc(id_pc),
    .id_pcadd4(id_pcadd4), .id_immext(id_immext), .id_gpr_rs(id_gpr_rs),
    .id_pred_npc(id_pred_npc), .flush(flush), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
    logic [31:0] redirect;
    logic        flush;
    bit          chk_pc;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  exp_t        sb[$];
  ent_t        btb[DEPTH];
  logic [31:0] m_pc = '0;
  bit          m_known = 1'b0;
  logic [31:0] if_pc = RPC, if_pred = RPC + 32'd4;
  int          checks = 0, errors = 0, cyc = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_pred(logic [31:0] pc);
    int i = idx_of(pc);
    if (BTB_ON && btb[i].v && btb[i].tag == (pc >> (IW + 2)) && btb[i].ctr >= 2) return btb[i].tgt;
    return pc + 32'd4;
  endfunction

  task automatic step(input bit r, input bit s, input bit v, input logic [1:0] k, input bit t,
                      input logic [31:0] ipc, input logic [31:0] imm, input logic [31:0] rs,
                      input logic [31:0] pn);
    logic [31:0] add4, br, jt, act;
    exp_t e;
    int i;
    rst = r; stall = s; id_valid = v; id_kind = k; id_taken = t; id_pc = ipc;
    add4 = ipc + 32'd4;
    id_pcadd4 = add4; id_immext = imm; id_gpr_rs = rs; id_pred_npc = pn;
    br = add4 + (imm << 2);
    jt = {add4[31:28], imm[25:0], 2'b00};
    case (k)
      2'd1: act = t ? br : add4;
      2'd2: act = jt;
      2'd3: act = rs;
      default: act = add4;
    endcase
    e.pc = m_pc; e.pred = model_pred(m_pc); e.flush = v && (act != pn);
    e.redirect = act; e.chk_pc = m_known; e.cyc = cyc;
    sb.push_back(e);
    if_pc = m_pc; if_pred = e.pred;
    if (r) begin
      m_pc = RPC; m_known = 1'b1;
      for (int j = 0; j < DEPTH; j++) btb[j].v = 1'b0;
    end else begin
      if (v && (k == 2'd1 || k == 2'd2)) begin
        i = idx_of(ipc);
        if (k == 2'd2) btb[i].ctr = 3;
        else if (!(btb[i].v && btb[i].tag == (ipc >> (IW + 2)))) btb[i].ctr = t ? 2 : 1;
        else if (t) btb[i].ctr = (btb[i].ctr == 3) ? 3 : btb[i].ctr + 1;
        else btb[i].ctr = (btb[i].ctr == 0) ? 0 : btb[i].ctr - 1;
        btb[i].v = 1'b1; btb[i].tag = ipc >> (IW + 2); btb[i].tgt = (k == 2'd2) ? jt : br;
      end
      if (e.flush) m_pc = act;
      else if (!s) m_pc = e.pred;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit s);
    step(1'b0, s, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic jr_to(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, if_pc, 32'h0, a, a ^ 32'h4);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("flush", {31'b0, flush}, {31'b0, e.flush}, e.cyc);
        if (e.flush) cmp("redirect_pc", redirect_pc, e.redirect, e.cyc);
        if (e.chk_pc) begin
          cmp("pc_if", pc_if, e.pc, e.cyc);
          cmp("pred_npc_if", pred_npc_if, e.pred, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] ipc, pn, imm;
    logic [1:0]  k;
    rst = 1'b1; stall = 1'b0; id_valid = 1'b0; id_kind = 2'd0; id_taken = 1'b0;
    id_pc = '0; id_pcadd4 = '0; id_immext = '0; id_gpr_rs = '0; id_pred_npc = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) idle(1'b0);
    // Cold taken branch, then return to it and three not-taken resolutions.
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h3010, 32'h4, 32'h0, 32'h3014);
    jr_to(32'h3010);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h3010, 32'h4, 32'h0, 32'h3014);
    repeat (3) step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h3010, 32'h4, 32'h0, 32'h3014);
    jr_to(32'h3010);
    idle(1'b0);
    // Jump into the BTB, then an indirect jump that must not be cached.
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h301C, 32'h0000_0C40, 32'h0, 32'h3020);
    jr_to(32'h301C);
    idle(1'b0);
    jr_to(32'h3400);
    jr_to(32'h3400);
    idle(1'b0);
    repeat (3) idle(1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h3200, 32'h0);
    idle(1'b0);
    // Wrap of PC + 4 and of a branch target at the top of the address space.
    jr_to(32'hFFFF_FFFC);
    idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'hFFFF_FFF4, 32'h4, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'h3000, 32'h0, 32'h3300, 32'h0);
    idle(1'b0);
    for (int n = 0; n < 2000; n++) begin
      k = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        ipc = if_pc; pn = if_pred;
      end else begin
        ipc = 32'h3000 + 32'(4 * $urandom_range(0, 63));
        pn = ($urandom_range(0, 1) == 1) ? ipc + 32'd4 : 32'h3000 + 32'(4 * $urandom_range(0, 63));
      end
      if (k == 2'd2) imm = (32'h3000 >> 2) + 32'($urandom_range(0, 63));
      else imm = 32'($urandom_range(0, 31)) - 32'd16;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           k, 1'($urandom_range(0, 1)), ipc, imm, 32'h3000 + 32'(4 * $urandom_range(0, 63)), pn);
    end
    idle(1'b0);
    repeat (2) @(posedge clk);
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
